// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one request/reply channel; the requester is master, the responder is slave.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [31:0]           write_data;
    logic [3:0]            write_mask;
    logic                  rep;
    logic [63:0]           rep_data;

    modport master (
        output req, addr, write, write_data, write_mask,
        input  rep, rep_data
    );

    modport slave (
        input  req, addr, write, write_data, write_mask,
        output rep, rep_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the I-cache or D-cache one memory transaction at a time and routes the reply back.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate ties between the ports instead of favouring the D-cache.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  icache,
    mem_arbiter_if.slave  dcache,
    mem_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_write_q;
    logic [31:0]           mem_write_data_q;
    logic [3:0]            mem_write_mask_q;
    logic                  i_rep_q;
    logic                  d_rep_q;
    logic [63:0]           i_rep_data_q;
    logic [63:0]           d_rep_data_q;
    logic                  dc_first;
    logic                  grant_dc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic dc_first_q;
    assign dc_first = dc_first_q;
`else
    assign dc_first = 1'b1;
`endif

    // dc_first only matters when both caches are requesting
    assign grant_dc = dcache.req & (~icache.req | dc_first);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= 1'b1;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_q      <= 1'b0;
            mem_write_data_q <= '0;
            mem_write_mask_q <= '0;
            i_rep_q          <= 1'b0;
            d_rep_q          <= 1'b0;
            i_rep_data_q     <= '0;
            d_rep_data_q     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            dc_first_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (icache.req | dcache.req) begin
                    state_q          <= BUSY;
                    owner_q          <= grant_dc;
                    mem_req_q        <= 1'b1;
                    mem_addr_q       <= grant_dc ? dcache.addr : icache.addr;
                    mem_write_q      <= grant_dc ? dcache.write : icache.write;
                    mem_write_data_q <= grant_dc ? dcache.write_data : icache.write_data;
                    mem_write_mask_q <= grant_dc ? dcache.write_mask : icache.write_mask;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    dc_first_q       <= ~grant_dc;
`endif
                end
                BUSY: if (mem.rep) begin
                    state_q   <= RESP;
                    mem_req_q <= 1'b0;
                    if (owner_q) begin
                        d_rep_q      <= 1'b1;
                        d_rep_data_q <= mem.rep_data;
                    end else begin
                        i_rep_q      <= 1'b1;
                        i_rep_data_q <= mem.rep_data;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    i_rep_q <= 1'b0;
                    d_rep_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.req        = mem_req_q;
    assign mem.addr       = mem_addr_q;
    assign mem.write      = mem_write_q;
    assign mem.write_data = mem_write_data_q;
    assign mem.write_mask = mem_write_mask_q;
    assign icache.rep      = i_rep_q;
    assign icache.rep_data = i_rep_data_q;
    assign dcache.rep      = d_rep_q;
    assign dcache.rep_data = d_rep_data_q;
endmodule
